// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered logic unit: op-field width and op codes.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational bitwise operation and result flags; popcount output exists
// only when LOGIC_UNIT_POPCOUNT_EN is defined.
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int POP_W = $clog2(WIDTH + 1)
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
`ifdef LOGIC_UNIT_POPCOUNT_EN
  output logic [POP_W-1:0] pop,
`endif
  output logic             neg
);

  always_comb begin
    y = a;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

  assign zero = (y == '0);
  assign neg  = y[WIDTH-1];

`ifdef LOGIC_UNIT_POPCOUNT_EN
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(y[i]);
    end
  end
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with a main/skid two-entry buffer so in_ready comes
// straight from a flop. Optional out_pop port under LOGIC_UNIT_POPCOUNT_EN.
//
// Handshake: a beat transfers on any rising edge where valid && ready; once
// out_valid rises it holds, with out_y/flags stable, until out_ready accepts it.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int POP_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
`ifdef LOGIC_UNIT_POPCOUNT_EN
  output logic [POP_W-1:0] out_pop,
`endif
  output logic             out_neg
);

  logic [WIDTH-1:0] new_y;
  logic             new_zero;
  logic             new_neg;

  logic             main_valid;
  logic [WIDTH-1:0] main_y;
  logic             main_zero;
  logic             main_neg;

  logic             skid_valid;
  logic [WIDTH-1:0] skid_y;
  logic             skid_zero;
  logic             skid_neg;

  logic in_fire;
  logic drain;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [POP_W-1:0] new_pop;
  logic [POP_W-1:0] main_pop;
  logic [POP_W-1:0] skid_pop;
`endif

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .y    (new_y),
    .zero (new_zero),
`ifdef LOGIC_UNIT_POPCOUNT_EN
    .pop  (new_pop),
`endif
    .neg  (new_neg)
  );

  assign in_fire = in_valid && in_ready;
  assign drain   = main_valid && out_ready;

  // skid_valid is a flop, so in_ready has no combinational path from out_ready.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_y     <= '0;
      main_zero  <= 1'b1;
      main_neg   <= 1'b0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_zero  <= 1'b1;
      skid_neg   <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        // in_ready was low, so no new beat can arrive this cycle
        main_y     <= skid_y;
        main_zero  <= skid_zero;
        main_neg   <= skid_neg;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_y    <= new_y;
        main_zero <= new_zero;
        main_neg  <= new_neg;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_y     <= new_y;
        main_zero  <= new_zero;
        main_neg   <= new_neg;
      end else begin
        skid_valid <= 1'b1;
        skid_y     <= new_y;
        skid_zero  <= new_zero;
        skid_neg   <= new_neg;
      end
    end
  end

`ifdef LOGIC_UNIT_POPCOUNT_EN
  // Popcount follows exactly the same entry movement as the result above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pop <= '0;
      skid_pop <= '0;
    end else if (drain) begin
      if (skid_valid) begin
        main_pop <= skid_pop;
      end else if (in_fire) begin
        main_pop <= new_pop;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_pop <= new_pop;
      end else begin
        skid_pop <= new_pop;
      end
    end
  end

  assign out_pop = main_pop;
`endif

  assign out_valid = main_valid;
  assign out_y     = main_y;
  assign out_zero  = main_zero;
  assign out_neg   = main_neg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: 16-bit instance for ops, backpressure,
// zero flag and mid-operation reset, plus an 8-bit instance for width.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_y;
  logic             out_zero;
  logic             out_neg;

  logic             n_in_valid = 1'b0;
  logic             n_in_ready;
  logic [2:0]       n_in_op = '0;
  logic [7:0]       n_in_a = '0;
  logic [7:0]       n_in_b = '0;
  logic             n_out_valid;
  logic             n_out_ready = 1'b1;
  logic [7:0]       n_out_y;
  logic             n_out_zero;
  logic             n_out_neg;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [4:0] out_pop;
  logic [3:0] n_out_pop;
`endif

  int checks = 0;
  int errors = 0;

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
`ifdef LOGIC_UNIT_POPCOUNT_EN
    .out_pop   (out_pop),
`endif
    .out_neg   (out_neg)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_op     (n_in_op),
    .in_a      (n_in_a),
    .in_b      (n_in_b),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_y     (n_out_y),
    .out_zero  (n_out_zero),
`ifdef LOGIC_UNIT_POPCOUNT_EN
    .out_pop   (n_out_pop),
`endif
    .out_neg   (n_out_neg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one beat at a negedge, let one rising edge pass, then sample at
  // the following negedge with in_valid dropped.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_op = $urandom_range(0, 7);
    in_a = 16'($urandom);
    in_b = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_y",     32'(out_y),     32'h0);
    chk("rst_out_zero",  32'(out_zero),  32'd1);
    chk("rst_out_neg",   32'(out_neg),   32'd0);
    chk("rst8_out_zero", 32'(n_out_zero), 32'd1);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    chk("rst_out_pop",   32'(out_pop),   32'd0);
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // all ops, a=0095 b=00BA
    send(OP_NOT, 16'h0095, 16'h00BA);
    chk("not_valid", 32'(out_valid), 32'd1);
    chk("not_y",     32'(out_y),     32'hFF6A);
    chk("not_neg",   32'(out_neg),   32'd1);
    chk("not_zero",  32'(out_zero),  32'd0);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    chk("not_pop",   32'(out_pop),   32'd12);
`endif
    send(OP_AND, 16'h0095, 16'h00BA);
    chk("and_y",   32'(out_y),   32'h0090);
    chk("and_neg", 32'(out_neg), 32'd0);
    send(OP_OR, 16'h0095, 16'h00BA);
    chk("or_y", 32'(out_y), 32'h00BF);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    chk("or_pop", 32'(out_pop), 32'd7);
`endif
    send(OP_XOR, 16'h0095, 16'h00BA);
    chk("xor_y", 32'(out_y), 32'h002F);
    send(OP_NAND, 16'h0095, 16'h00BA);
    chk("nand_y",   32'(out_y),   32'hFF6F);
    chk("nand_neg", 32'(out_neg), 32'd1);
    send(OP_NOR, 16'h0095, 16'h00BA);
    chk("nor_y", 32'(out_y), 32'hFF40);
    send(OP_XNOR, 16'h0095, 16'h00BA);
    chk("xnor_y", 32'(out_y), 32'hFFD0);
    send(OP_PASS, 16'h0095, 16'h00BA);
    chk("pass_y",     32'(out_y),     32'h0095);
    chk("pass_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // back-to-back beats at full throughput
    in_valid = 1'b1; in_op = OP_AND; in_a = 16'h0095; in_b = 16'h00BA;
    @(negedge clk);
    chk("b2b_1_y", 32'(out_y), 32'h0090);
    in_op = OP_OR;
    @(negedge clk);
    chk("b2b_2_y",     32'(out_y),    32'h00BF);
    chk("b2b_2_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // backpressure: three beats with out_ready low
    out_ready = 1'b0;
    send(OP_AND, 16'h0095, 16'h00BA);
    chk("bp1_valid", 32'(out_valid), 32'd1);
    chk("bp1_ready", 32'(in_ready),  32'd1);
    send(OP_OR, 16'h0095, 16'h00BA);
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_y",     32'(out_y),    32'h0090);
    in_valid = 1'b1; in_op = OP_XOR; in_a = 16'h0095; in_b = 16'h00BA;
    @(negedge clk);
    chk("bp3_stall_ready", 32'(in_ready), 32'd0);
    chk("bp3_stable_y",    32'(out_y),    32'h0090);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out2_y",     32'(out_y),    32'h00BF);
    chk("bp_out2_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out3_y",     32'(out_y),     32'h002F);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // zero flag, 16-bit and 8-bit
    send(OP_XOR, 16'hFFFF, 16'hFFFF);
    chk("zero16_y",    32'(out_y),    32'h0);
    chk("zero16_zero", 32'(out_zero), 32'd1);
    chk("zero16_neg",  32'(out_neg),  32'd0);
    n_in_valid = 1'b1; n_in_op = OP_NOR; n_in_a = 8'hF0; n_in_b = 8'h0F;
    @(negedge clk);
    n_in_valid = 1'b0;
    chk("zero8_valid", 32'(n_out_valid), 32'd1);
    chk("zero8_y",     32'(n_out_y),     32'h00);
    chk("zero8_zero",  32'(n_out_zero),  32'd1);
    n_in_valid = 1'b1; n_in_op = OP_NOT; n_in_a = 8'h35;
    @(negedge clk);
    n_in_valid = 1'b0;
    chk("not8_y",   32'(n_out_y),   32'hCA);
    chk("not8_neg", 32'(n_out_neg), 32'd1);

    // reset with both entries full
    out_ready = 1'b0;
    send(OP_AND, 16'h0095, 16'h00BA);
    send(OP_OR, 16'h0095, 16'h00BA);
    chk("prerst_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    chk("midrst_y",     32'(out_y),     32'h0);
    chk("midrst_zero",  32'(out_zero),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    send(OP_PASS, 16'h1234, 16'h0000);
    chk("postrst_y",     32'(out_y),     32'h1234);
    chk("postrst_valid2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("postrst_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
